// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger pulse, echo pulse-width measurement
// in centimetres with saturation at MAX_CM and a timeout when no echo arrives.
module hc_sr04_ranger #(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int IDLE_MS       = 60,
    parameter int TRIG_US       = 10,
    parameter int TIMEOUT_US    = 10_000,
    parameter int MAX_CM        = 400,
    parameter int DIST_WIDTH    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  echo,
    output logic                  trig,
    output logic [DIST_WIDTH-1:0] distance,
    output logic                  valid,
    output logic                  out_of_range,
    output logic                  timeout,
    output logic                  busy
);

    localparam int CPU    = CLK_FREQUENCY / 1_000_000;
    localparam int CPC    = CPU * 58;
    localparam int IDLE_C = IDLE_MS * CPU * 1000;
    localparam int TRIG_C = TRIG_US * CPU;
    localparam int TMO_C  = TIMEOUT_US * CPU;

    localparam int PH_MAX0 = (IDLE_C > TRIG_C) ? IDLE_C : TRIG_C;
    localparam int PH_MAX  = (PH_MAX0 > TMO_C) ? PH_MAX0 : TMO_C;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int PS_W    = $clog2(CPC);
    localparam int CM_W    = $clog2(MAX_CM + 1);

    if ((64'd1 << DIST_WIDTH) <= 64'(MAX_CM)) begin : g_dist_width_check
        $error("hc_sr04_ranger: DIST_WIDTH cannot represent MAX_CM");
    end

    if (CPU < 1 || IDLE_C < 1 || TRIG_C < 1 || TMO_C < 1 || MAX_CM < 1) begin : g_param_check
        $error("hc_sr04_ranger: timing parameters must be at least one cycle");
    end

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [PS_W-1:0]       presc_q, presc_d;
    logic [CM_W-1:0]       cm_q, cm_d;
    logic                  trig_q, trig_d;
    logic [DIST_WIDTH-1:0] dist_q, dist_d;
    logic                  valid_q, valid_d;
    logic                  oor_q, oor_d;
    logic                  tmo_q, tmo_d;

    logic echo_s1_q, echo_s2_q, echo_h_q;
    logic echo_rise, echo_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_h_q  <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_h_q  <= echo_s2_q;
        end
    end

    assign echo_rise = echo_s2_q & ~echo_h_q;
    assign echo_fall = ~echo_s2_q & echo_h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_q    <= '0;
            presc_q <= '0;
            cm_q    <= '0;
            trig_q  <= 1'b0;
            dist_q  <= '0;
            valid_q <= 1'b0;
            oor_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            presc_q <= presc_d;
            cm_q    <= cm_d;
            trig_q  <= trig_d;
            dist_q  <= dist_d;
            valid_q <= valid_d;
            oor_q   <= oor_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        presc_d = presc_q;
        cm_d    = cm_q;
        trig_d  = trig_q;
        dist_d  = dist_q;
        valid_d = 1'b0;
        oor_d   = oor_q;
        tmo_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ph_q == PH_W'(IDLE_C - 1)) begin
                    if (enable) begin
                        state_d = TRIG;
                        ph_d    = '0;
                        trig_d  = 1'b1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            TRIG: begin
                if (ph_q == PH_W'(TRIG_C - 1)) begin
                    state_d = WAIT_ECHO;
                    ph_d    = '0;
                    trig_d  = 1'b0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            WAIT_ECHO: begin
                if (echo_rise) begin
                    // The rise cycle is itself the first high cycle, so the
                    // prescaler starts at 1 to make distance = floor(N/CPC).
                    state_d = MEASURE;
                    ph_d    = '0;
                    presc_d = PS_W'(1);
                    cm_d    = '0;
                end else if (ph_q == PH_W'(TMO_C - 1)) begin
                    state_d = IDLE;
                    ph_d    = '0;
                    tmo_d   = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            MEASURE: begin
                if (echo_fall) begin
                    state_d = IDLE;
                    ph_d    = '0;
                    dist_d  = DIST_WIDTH'(cm_q);
                    oor_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (presc_q == PS_W'(CPC - 1)) begin
                    presc_d = '0;
                    if (cm_q == CM_W'(MAX_CM - 1)) begin
                        state_d = IDLE;
                        ph_d    = '0;
                        cm_d    = CM_W'(MAX_CM);
                        dist_d  = DIST_WIDTH'(MAX_CM);
                        oor_d   = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        cm_d = cm_q + CM_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                ph_d    = '0;
                trig_d  = 1'b0;
            end
        endcase
    end

    assign trig         = trig_q;
    assign distance     = dist_q;
    assign valid        = valid_q;
    assign out_of_range = oor_q;
    assign timeout      = tmo_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hc_sr04_ranger.sv
// Self-checking bench for hc_sr04_ranger at 1 MHz: random echo widths checked
// against an arithmetic distance model, plus timeout, enable and reset scenarios.
module tb_hc_sr04_ranger;

    localparam int CPC    = 58;
    localparam int MAXCM  = 20;
    localparam int IDLEC  = 1000;
    localparam int TRIGC  = 10;
    localparam int TMOC   = 2000;
    localparam int DW     = 9;
    localparam int SAT_N  = MAXCM * CPC;

    logic          clk = 1'b0;
    logic          rst_n, enable, echo;
    logic          trig, valid, out_of_range, timeout, busy;
    logic [DW-1:0] distance;

    int unsigned cyc = 0;
    int nvec = 0;
    int nerr = 0;
    int exp_dist = 0;
    bit exp_oor  = 1'b0;

    hc_sr04_ranger #(
        .CLK_FREQUENCY(1_000_000),
        .IDLE_MS(1),
        .TRIG_US(10),
        .TIMEOUT_US(2000),
        .MAX_CM(MAXCM),
        .DIST_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .echo(echo),
        .trig(trig),
        .distance(distance),
        .valid(valid),
        .out_of_range(out_of_range),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_dist(input int n);
        return (n >= SAT_N) ? MAXCM : n / CPC;
    endfunction

    task automatic wait_trig_fall(output int unsigned t_fall, output bit ok);
        int k = 0;
        ok = 1'b1;
        while (trig !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        k = 0;
        while (trig !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        t_fall = cyc;
        if (trig !== 1'b0 || k == 0) begin
            nvec++; nerr++; ok = 1'b0;
            $display("FAIL trig_wait: no trig pulse within bound (trig=%b)", trig);
        end
    endtask

    task automatic test_reset();
        int unsigned t0, t_rise;
        int k, width;
        rst_n = 1'b0; enable = 1'b1; echo = 1'b0;
        repeat (5) @(negedge clk);
        nvec++; if (trig !== 1'b0)         begin nerr++; $display("FAIL rst_trig: got %b want 0", trig); end
        nvec++; if (distance !== '0)       begin nerr++; $display("FAIL rst_distance: got %0d want 0", distance); end
        nvec++; if (valid !== 1'b0)        begin nerr++; $display("FAIL rst_valid: got %b want 0", valid); end
        nvec++; if (out_of_range !== 1'b0) begin nerr++; $display("FAIL rst_oor: got %b want 0", out_of_range); end
        nvec++; if (timeout !== 1'b0)      begin nerr++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1; t0 = cyc;
        k = 0;
        while (trig !== 1'b1 && k < 1200) begin @(negedge clk); k++; end
        t_rise = cyc;
        nvec++; if (trig !== 1'b1 || t_rise - t0 != IDLEC)
            begin nerr++; $display("FAIL first_trig: got %0d clocks want %0d", t_rise - t0, IDLEC); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL busy_at_trig: got %b want 1", busy); end
        width = 0;
        while (trig === 1'b1 && width < 50) begin width++; @(negedge clk); end
        nvec++; if (width != TRIGC) begin nerr++; $display("FAIL trig_width: got %0d want %0d", width, TRIGC); end
    endtask

    task automatic run_measure(input int n, input int gap, input bit drop_en);
        int unsigned tf, t_rise, t_low, t_valid;
        int vcount, tcount, exp_d;
        bit ok, exp_sat;
        logic [DW-1:0] d_seen;
        logic o_seen;
        vcount = 0; tcount = 0; t_valid = 0; d_seen = 'x; o_seen = 1'bx;
        wait_trig_fall(tf, ok);
        if (!ok) return;
        repeat (gap) @(negedge clk);
        echo = 1'b1; t_rise = cyc;
        for (int i = 0; i < n + 8; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin vcount++; t_valid = cyc; d_seen = distance; o_seen = out_of_range; end
            if (timeout === 1'b1) tcount++;
            if (drop_en && i == n / 2) enable = 1'b0;
            if (i == n - 1) begin echo = 1'b0; t_low = cyc; end
        end
        exp_sat = (n >= SAT_N);
        exp_d   = model_dist(n);
        nvec++; if (vcount != 1) begin nerr++; $display("FAIL valid_count n=%0d: got %0d want 1", n, vcount); end
        nvec++; if (tcount != 0) begin nerr++; $display("FAIL spurious_timeout n=%0d: got %0d want 0", n, tcount); end
        nvec++; if (d_seen !== DW'(exp_d))
            begin nerr++; $display("FAIL distance n=%0d: got %0d want %0d", n, d_seen, exp_d); end
        nvec++; if (o_seen !== exp_sat)
            begin nerr++; $display("FAIL out_of_range n=%0d: got %b want %b", n, o_seen, exp_sat); end
        if (!exp_sat) begin
            nvec++; if (t_valid != t_low + 3)
                begin nerr++; $display("FAIL valid_latency n=%0d: got %0d want 3", n, t_valid - t_low); end
            nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL busy_after n=%0d: got %b want 0", n, busy); end
        end else begin
            nvec++; if (t_valid < t_rise + SAT_N + 1 || t_valid > t_rise + SAT_N + 3)
                begin nerr++; $display("FAIL sat_latency n=%0d: got %0d want %0d..%0d", n, t_valid - t_rise, SAT_N + 1, SAT_N + 3); end
        end
        exp_dist = exp_d;
        exp_oor  = exp_sat;
    endtask

    task automatic check_no_echo_timeout(input string tag);
        int unsigned tf, t_to, t_trig;
        int tcount, vcount, k;
        bit ok;
        tcount = 0; vcount = 0; t_to = 0;
        wait_trig_fall(tf, ok);
        if (!ok) return;
        for (int i = 0; i < TMOC + 10; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin tcount++; t_to = cyc; end
            if (valid === 1'b1) vcount++;
        end
        echo = 1'b0;
        nvec++; if (tcount != 1) begin nerr++; $display("FAIL %s_count: got %0d want 1", tag, tcount); end
        nvec++; if (t_to != tf + TMOC) begin nerr++; $display("FAIL %s_delay: got %0d want %0d", tag, t_to - tf, TMOC); end
        nvec++; if (vcount != 0) begin nerr++; $display("FAIL %s_valid: got %0d want 0", tag, vcount); end
        nvec++; if (distance !== DW'(exp_dist) || out_of_range !== exp_oor)
            begin nerr++; $display("FAIL %s_hold: got %0d/%b want %0d/%b", tag, distance, out_of_range, exp_dist, exp_oor); end
        k = 0;
        while (trig !== 1'b1 && k < 1200) begin @(negedge clk); k++; end
        t_trig = cyc;
        nvec++; if (trig !== 1'b1 || t_trig != t_to + IDLEC)
            begin nerr++; $display("FAIL %s_next_trig: got %0d want %0d", tag, t_trig - t_to, IDLEC); end
    endtask

    task automatic test_fixed_distances();
        run_measure(580, 20, 1'b0);
        run_measure(579, 5, 1'b0);
    endtask

    task automatic test_timeout();
        check_no_echo_timeout("timeout");
    endtask

    task automatic test_saturation();
        run_measure(3000, 7, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_measure(int'($urandom_range(1, 1250)), int'($urandom_range(0, 300)), 1'b0);
        run_measure(int'($urandom_range(1, 1100)), int'($urandom_range(0, 300)), 1'b0);
    endtask

    task automatic test_ignored_echo();
        int k = 0;
        while (busy !== 1'b0 && k < 6000) begin @(negedge clk); k++; end
        echo = 1'b1;
        check_no_echo_timeout("held_echo");
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        run_measure(700, int'($urandom_range(0, 100)), 1'b1);
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (trig !== 1'b0 || busy !== 1'b0) bad++;
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL parked_idle: got %0d active cycles want 0", bad); end
        enable = 1'b1;
        @(negedge clk);
        nvec++; if (trig !== 1'b1) begin nerr++; $display("FAIL resume_trig: got %b want 1", trig); end
    endtask

    task automatic test_reset_mid_trig();
        int unsigned t0;
        int k = 0;
        while (trig !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (trig !== 1'b0) begin nerr++; $display("FAIL async_trig_drop: got %b want 0", trig); end
        nvec++; if ({distance, valid, out_of_range, timeout, busy} !== '0)
            begin nerr++; $display("FAIL async_outputs: got %0d/%b/%b/%b/%b want all 0", distance, valid, out_of_range, timeout, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1; t0 = cyc;
        k = 0;
        while (trig !== 1'b1 && k < 1200) begin @(negedge clk); k++; end
        nvec++; if (trig !== 1'b1 || cyc - t0 != IDLEC)
            begin nerr++; $display("FAIL trig_after_reset: got %0d want %0d", cyc - t0, IDLEC); end
    endtask

    initial begin
        test_reset();
        test_fixed_distances();
        test_timeout();
        test_saturation();
        test_random();
        test_ignored_echo();
        test_enable_drop();
        test_reset_mid_trig();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
